uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receiver. Configurable bit period, data width, parity and stop bits; validates start bit, checks parity and stop bits, and buffers received words in a small first-word-fall-through FIFO drained by a valid/ready handshake. Sits between the board serial pin and the core's input/loader logic.

Parameters:
CLK_PER_BIT, 2604, clocks per serial bit (>=4).
DATA_BITS, 8, data bits per frame (5..9), LSB first.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, stop bits per frame (1 or 2).
FIFO_DEPTH, 4, FIFO entries (power of 2, >=2).

Ports:
CLK  in  1  system clock.
RST_N  in  1  reset, asynchronous, active-low.
IN  in  1  serial line, idle high, asynchronous to CLK.
data  out  DATA_BITS  FIFO head word; meaningful only while valid=1.
valid  out  1  FIFO not empty.
ready  in  1  consumer accepts head; pop when valid & ready.
count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
framing_err  out  1  sticky: a stop bit sampled low.
parity_err  out  1  sticky: parity mismatch.
overrun  out  1  sticky: good word dropped because FIFO full.
err_clr  in  1  clears all three sticky flags.

Behaviour:
- Reset (RST_N low, async): state IDLE, bit counter and baud counter 0, synchroniser flops = 1, FIFO empty (valid=0, count=0, data=0), all error flags 0. Reset mid-frame abandons the frame; no partial word is ever pushed.
- IN passes through a 2-flop synchroniser (reset value 1); all logic uses the synchronised value rx.
- Baud counter runs 0..CLK_PER_BIT-1 and wraps; it is cleared on every state entry from IDLE.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: rx=0 -> START, baud counter=0.
- START: at baud count CLK_PER_BIT/2-1 sample rx; 1 -> IDLE (glitch rejected, no flag); 0 -> DATA with baud counter cleared. All later samples fall every CLK_PER_BIT clocks, i.e. mid-bit.
- DATA: shift in DATA_BITS samples LSB first; after last -> PARITY if PARITY!=0, else STOP.
- PARITY: one sample; odd mode requires odd count of ones over data+parity bit, even mode even count.
- STOP: STOP_BITS samples; any low sample -> framing error -> WAIT_HIGH. All high -> IDLE.
- WAIT_HIGH: stay until rx=1, then IDLE (prevents a held-low line/break from retriggering).
- Frame end: on the cycle after the final stop sample, if no framing and no parity error the word is pushed. Framing or parity error: word discarded, corresponding flag set; both may set on the same frame.
- FIFO: FWFT; data/valid reflect head combinationally from storage. Push visible on valid/data 1 cycle after the final stop-sample edge.
- Push when full: accepted only if a pop occurs in the same cycle (count unchanged); otherwise word dropped, overrun set, FIFO contents untouched.
- Push and pop same cycle when not full/not empty: count unchanged. Pop when empty: ignored. Pointers wrap mod FIFO_DEPTH.
- Sticky flags: set by event, cleared by err_clr; event in the same cycle as err_clr -> flag ends 1.
- Receiver never stalls on the FIFO; the next start bit is accepted in IDLE immediately after the stop bit(s).

Test Plan:
- CLK_PER_BIT=16, 8N1: send 0xA5, ready=1 -> valid pulses 1 cycle with data=0xA5 one cycle after stop sample; count returns 0; no flags.
- Start glitch: IN low 5 clocks then high, CLK_PER_BIT=16 -> stays IDLE, no push, no flags; following frame 0x3C received correctly.
- PARITY=2 (even): send 0x07 with parity bit 1 -> pushed 0x07; send 0x07 with parity bit 0 -> no push, parity_err=1 until err_clr pulse.
- Stop bit forced 0 on 0x81, IN held low 40 clocks -> framing_err=1, no push, no new frame until IN returns high; next 0x42 received.
- ready=0, FIFO_DEPTH=4: send 5 words 0x01..0x05 -> count=4, data=0x01, overrun=1; drain -> 0x01,0x02,0x03,0x04 in order.
- Full FIFO, ready asserted exactly on 5th word's push cycle -> 0x05 accepted, count stays 4, overrun=0; RST_N pulse mid-frame -> all outputs reset, no partial word.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver (start/data/parity/stop validation) feeding a
// small first-word-fall-through FIFO drained by a valid/ready handshake.
module uart_rx_fifo #(
  parameter int CLK_PER_BIT = 2604,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          IN,
  output logic [DATA_BITS-1:0]          data,
  output logic                          valid,
  input  logic                          ready,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          framing_err,
  output logic                          parity_err,
  output logic                          overrun,
  input  logic                          err_clr
);

  localparam int BAUD_W = $clog2(CLK_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam int AW     = $clog2(FIFO_DEPTH);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic [AW:0]       FULL_CNT  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_e;

  logic rx_meta_q, rx_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_meta_q <= 1'b1;
      rx_q      <= 1'b1;
    end else begin
      rx_meta_q <= IN;
      rx_q      <= rx_meta_q;
    end
  end

  state_e                state_q;
  logic [BAUD_W-1:0]     baud_q;
  logic [BIT_W-1:0]      bit_q;
  logic [DATA_BITS-1:0]  shift_q;
  logic                  par_q;
  logic                  perr_q;
  logic                  push_q;
  logic                  ferr_ev_q;
  logic                  perr_ev_q;

  // Frame-end events are registered, so the push lands one cycle after the
  // final stop sample; shift_q stays stable until the next frame's data bits.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
      push_q    <= 1'b0;
      ferr_ev_q <= 1'b0;
      perr_ev_q <= 1'b0;
    end else begin
      push_q    <= 1'b0;
      ferr_ev_q <= 1'b0;
      perr_ev_q <= 1'b0;
      baud_q    <= (baud_q == BAUD_LAST) ? '0 : baud_q + 1'b1;
      case (state_q)
        S_IDLE: begin
          baud_q <= '0;
          bit_q  <= '0;
          par_q  <= 1'b0;
          perr_q <= 1'b0;
          if (!rx_q) state_q <= S_START;
        end
        S_START: begin
          if (baud_q == BAUD_HALF) begin
            baud_q  <= '0;
            state_q <= rx_q ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (baud_q == BAUD_LAST) begin
            shift_q <= {rx_q, shift_q[DATA_BITS-1:1]};
            par_q   <= par_q ^ rx_q;
            if (bit_q == DATA_LAST) begin
              bit_q   <= '0;
              state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (baud_q == BAUD_LAST) begin
            perr_q  <= (PARITY == 1) ? ~(par_q ^ rx_q) : (par_q ^ rx_q);
            state_q <= S_STOP;
          end
        end
        S_STOP: begin
          if (baud_q == BAUD_LAST) begin
            if (!rx_q) begin
              ferr_ev_q <= 1'b1;
              perr_ev_q <= perr_q;
              state_q   <= S_WAIT_HIGH;
            end else if (bit_q == STOP_LAST) begin
              push_q    <= ~perr_q;
              perr_ev_q <= perr_q;
              state_q   <= S_IDLE;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end
        end
        S_WAIT_HIGH: begin
          if (rx_q) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          count_q, count_d;
  logic                 full, pop, push_ok, overrun_ev;

  assign valid      = (count_q != '0);
  assign full       = (count_q == FULL_CNT);
  assign pop        = valid & ready;
  assign push_ok    = push_q & (~full | pop);
  assign overrun_ev = push_q & full & ~pop;
  assign data       = valid ? mem_q[rd_ptr_q] : '0;
  assign count      = count_q;

  // NOTE: storage has no reset; valid gates data so stale entries never leak.
  always_ff @(posedge CLK) begin
    if (push_ok) mem_q[wr_ptr_q] <= shift_q;
  end

  // NOTE: give every always_comb output a default first so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      framing_err <= 1'b0;
      parity_err  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q     <= count_d;
      // A new event wins over a simultaneous clear.
      framing_err <= (framing_err & ~err_clr) | ferr_ev_q;
      parity_err  <= (parity_err  & ~err_clr) | perr_ev_q;
      overrun     <= (overrun     & ~err_clr) | overrun_ev;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: an 8N1 instance and an even-parity,
// two-stop-bit instance, both at 16 clocks per bit.
module tb_uart_rx_fifo;
  localparam int CPB = 16;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       in0 = 1'b1, in1 = 1'b1;
  logic       ready0 = 1'b0, ready1 = 1'b0;
  logic       clr0 = 1'b0, clr1 = 1'b0;
  logic [7:0] data0, data1;
  logic       valid0, valid1;
  logic [2:0] count0, count1;
  logic       fe0, pe0, ov0, fe1, pe1, ov1;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] sb0 [$];
  logic [7:0] sb1 [$];
  logic [7:0] exp0, exp1;
  int         vcnt0 = 0;
  int         lat = 150;

  always #5 CLK = ~CLK;

  uart_rx_fifo #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .CLK(CLK), .RST_N(RST_N), .IN(in0), .data(data0), .valid(valid0), .ready(ready0),
    .count(count0), .framing_err(fe0), .parity_err(pe0), .overrun(ov0), .err_clr(clr0));

  uart_rx_fifo #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (
    .CLK(CLK), .RST_N(RST_N), .IN(in1), .data(data1), .valid(valid1), .ready(ready1),
    .count(count1), .framing_err(fe1), .parity_err(pe1), .overrun(ov1), .err_clr(clr1));

  // Every accepted word is checked against the head of its scoreboard.
  always @(negedge CLK) begin
    if (RST_N) begin
      if (valid0) vcnt0++;
      if (valid0 && ready0) begin
        vectors++;
        if (sb0.size() == 0) begin
          miscompares++;
          $display("FAIL dut0_unexpected_word: got %h want none", data0);
        end else begin
          exp0 = sb0.pop_front();
          if (data0 !== exp0) begin
            miscompares++;
            $display("FAIL dut0_word: got %h want %h", data0, exp0);
          end
        end
      end
      if (valid1 && ready1) begin
        vectors++;
        if (sb1.size() == 0) begin
          miscompares++;
          $display("FAIL dut1_unexpected_word: got %h want none", data1);
        end else begin
          exp1 = sb1.pop_front();
          if (data1 !== exp1) begin
            miscompares++;
            $display("FAIL dut1_word: got %h want %h", data1, exp1);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic drive_in(input int d, input logic v);
    if (d == 0) in0 = v;
    else        in1 = v;
  endtask

  // Leaves the line at stop_v when done, so a low stop bit keeps it low.
  task automatic send_frame(input int d, input logic [7:0] w, input logic has_par,
                            input logic par, input int nstop, input logic stop_v);
    drive_in(d, 1'b0);
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      drive_in(d, w[i]);
      tick(CPB);
    end
    if (has_par) begin
      drive_in(d, par);
      tick(CPB);
    end
    for (int i = 0; i < nstop; i++) begin
      drive_in(d, stop_v);
      tick(CPB);
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    tick(3);
    vectors++;
    if ({valid0, count0, data0, fe0, pe0, ov0} !== 15'd0) begin
      miscompares++;
      $display("FAIL reset_dut0: got v=%b c=%0d d=%h f=%b%b%b want all 0",
               valid0, count0, data0, fe0, pe0, ov0);
    end
    vectors++;
    if ({valid1, count1, data1, fe1, pe1, ov1} !== 15'd0) begin
      miscompares++;
      $display("FAIL reset_dut1: got v=%b c=%0d d=%h f=%b%b%b want all 0",
               valid1, count1, data1, fe1, pe1, ov1);
    end
    RST_N = 1'b1;
    tick(5);
  endtask

  task automatic test_basic();
    int v;
    bit found;
    found = 1'b0;
    ready0 = 1'b1;
    v = vcnt0;
    sb0.push_back(8'hA5);
    fork
      send_frame(0, 8'hA5, 1'b0, 1'b0, 1, 1'b1);
      begin
        for (int k = 1; k <= 400; k++) begin
          tick(1);
          if (valid0) begin
            found = 1'b1;
            lat = k;
            break;
          end
        end
      end
    join
    tick(20);
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL a5_timeout: got no valid want valid within 400 cycles");
    end
    vectors++;
    if (vcnt0 - v != 1) begin
      miscompares++;
      $display("FAIL a5_valid_width: got %0d cycles want 1", vcnt0 - v);
    end
    vectors++;
    if (count0 !== 3'd0 || sb0.size() != 0) begin
      miscompares++;
      $display("FAIL a5_drained: got count=%0d pending=%0d want 0 0", count0, sb0.size());
    end
    vectors++;
    if ({fe0, pe0, ov0} !== 3'b000) begin
      miscompares++;
      $display("FAIL a5_flags: got %b want 000", {fe0, pe0, ov0});
    end
  endtask

  task automatic test_glitch();
    int v;
    v = vcnt0;
    in0 = 1'b0;
    tick(5);
    in0 = 1'b1;
    tick(30);
    vectors++;
    if (vcnt0 != v || count0 !== 3'd0 || {fe0, pe0, ov0} !== 3'b000) begin
      miscompares++;
      $display("FAIL glitch_ignored: got valids=%0d count=%0d flags=%b want 0 0 000",
               vcnt0 - v, count0, {fe0, pe0, ov0});
    end
    sb0.push_back(8'h3C);
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1, 1'b1);
    tick(20);
    vectors++;
    if (sb0.size() != 0) begin
      miscompares++;
      $display("FAIL glitch_next_frame: got pending=%0d want 0", sb0.size());
    end
  endtask

  task automatic test_parity();
    ready1 = 1'b1;
    sb1.push_back(8'h07);
    send_frame(1, 8'h07, 1'b1, 1'b1, 2, 1'b1);
    tick(20);
    vectors++;
    if (sb1.size() != 0 || pe1 !== 1'b0) begin
      miscompares++;
      $display("FAIL parity_good: got pending=%0d perr=%b want 0 0", sb1.size(), pe1);
    end
    send_frame(1, 8'h07, 1'b1, 1'b0, 2, 1'b1);
    tick(20);
    vectors++;
    if (pe1 !== 1'b1 || count1 !== 3'd0 || fe1 !== 1'b0) begin
      miscompares++;
      $display("FAIL parity_bad: got perr=%b count=%0d ferr=%b want 1 0 0", pe1, count1, fe1);
    end
    tick(10);
    vectors++;
    if (pe1 !== 1'b1) begin
      miscompares++;
      $display("FAIL parity_sticky: got %b want 1", pe1);
    end
    clr1 = 1'b1;
    tick(1);
    clr1 = 1'b0;
    vectors++;
    if (pe1 !== 1'b0) begin
      miscompares++;
      $display("FAIL parity_clear: got %b want 0", pe1);
    end
  endtask

  task automatic test_framing();
    send_frame(0, 8'h81, 1'b0, 1'b0, 1, 1'b0);
    tick(40);
    vectors++;
    if (fe0 !== 1'b1 || count0 !== 3'd0 || pe0 !== 1'b0) begin
      miscompares++;
      $display("FAIL framing_set: got ferr=%b count=%0d perr=%b want 1 0 0", fe0, count0, pe0);
    end
    in0 = 1'b1;
    tick(30);
    vectors++;
    if (count0 !== 3'd0) begin
      miscompares++;
      $display("FAIL framing_no_retrigger: got count=%0d want 0", count0);
    end
    clr0 = 1'b1;
    tick(1);
    clr0 = 1'b0;
    sb0.push_back(8'h42);
    send_frame(0, 8'h42, 1'b0, 1'b0, 1, 1'b1);
    tick(20);
    vectors++;
    if (sb0.size() != 0 || fe0 !== 1'b0) begin
      miscompares++;
      $display("FAIL framing_recover: got pending=%0d ferr=%b want 0 0", sb0.size(), fe0);
    end
  endtask

  task automatic test_overrun();
    ready0 = 1'b0;
    for (int w = 1; w <= 5; w++) begin
      if (w <= 4) sb0.push_back(8'(w));
      send_frame(0, 8'(w), 1'b0, 1'b0, 1, 1'b1);
    end
    tick(10);
    vectors++;
    if (count0 !== 3'd4 || valid0 !== 1'b1 || data0 !== 8'h01 || ov0 !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_full: got count=%0d valid=%b data=%h ovr=%b want 4 1 01 1",
               count0, valid0, data0, ov0);
    end
    ready0 = 1'b1;
    tick(10);
    ready0 = 1'b0;
    vectors++;
    if (count0 !== 3'd0 || sb0.size() != 0) begin
      miscompares++;
      $display("FAIL overrun_drain: got count=%0d pending=%0d want 0 0", count0, sb0.size());
    end
    clr0 = 1'b1;
    tick(1);
    clr0 = 1'b0;
    vectors++;
    if (ov0 !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun_clear: got %b want 0", ov0);
    end
  endtask

  task automatic test_full_pop();
    ready0 = 1'b0;
    for (int w = 0; w < 4; w++) begin
      sb0.push_back(8'h11 + 8'(w));
      send_frame(0, 8'h11 + 8'(w), 1'b0, 1'b0, 1, 1'b1);
    end
    tick(10);
    vectors++;
    if (count0 !== 3'd4) begin
      miscompares++;
      $display("FAIL fullpop_fill: got count=%0d want 4", count0);
    end
    sb0.push_back(8'h05);
    fork
      send_frame(0, 8'h05, 1'b0, 1'b0, 1, 1'b1);
      begin
        tick(lat - 1);
        ready0 = 1'b1;
        tick(1);
        ready0 = 1'b0;
      end
    join
    tick(10);
    vectors++;
    if (count0 !== 3'd4 || ov0 !== 1'b0 || data0 !== 8'h12) begin
      miscompares++;
      $display("FAIL fullpop_accept: got count=%0d ovr=%b head=%h want 4 0 12", count0, ov0, data0);
    end
    ready0 = 1'b1;
    tick(10);
    ready0 = 1'b0;
    vectors++;
    if (count0 !== 3'd0 || sb0.size() != 0) begin
      miscompares++;
      $display("FAIL fullpop_drain: got count=%0d pending=%0d want 0 0", count0, sb0.size());
    end
  endtask

  task automatic test_reset_mid();
    ready0 = 1'b0;
    send_frame(0, 8'h81, 1'b0, 1'b0, 1, 1'b0);
    in0 = 1'b1;
    tick(10);
    sb0.push_back(8'h33);
    send_frame(0, 8'h33, 1'b0, 1'b0, 1, 1'b1);
    tick(10);
    vectors++;
    if (count0 !== 3'd1 || fe0 !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_setup: got count=%0d ferr=%b want 1 1", count0, fe0);
    end
    fork
      send_frame(0, 8'hF0, 1'b0, 1'b0, 1, 1'b1);
      begin
        tick(40);
        RST_N = 1'b0;
        sb0.delete();
        tick(2);
        vectors++;
        if ({valid0, count0, data0, fe0, pe0, ov0} !== 15'd0) begin
          miscompares++;
          $display("FAIL rstmid_in_reset: got v=%b c=%0d d=%h f=%b%b%b want all 0",
                   valid0, count0, data0, fe0, pe0, ov0);
        end
        tick(48);
        RST_N = 1'b1;
      end
    join
    tick(30);
    vectors++;
    if ({valid0, count0, fe0, pe0, ov0} !== 7'd0) begin
      miscompares++;
      $display("FAIL rstmid_no_partial: got v=%b c=%0d f=%b%b%b want all 0",
               valid0, count0, fe0, pe0, ov0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_parity();
    test_framing();
    test_overrun();
    test_full_pop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
